// File: rtl/disp_freq_scan.sv
// disp_freq_scan: multiplexed N-digit 7-segment driver with shadow latch, leading-zero blanking and dead cycle
module disp_freq_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_en
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank;
  logic                    nz;
  logic                    dead;
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h7E;
      4'h1: decode = 7'h30;
      4'h2: decode = 7'h6D;
      4'h3: decode = 7'h79;
      4'h4: decode = 7'h33;
      4'h5: decode = 7'h5B;
      4'h6: decode = 7'h5F;
      4'h7: decode = 7'h70;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h73;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h1F;
      4'hC: decode = 7'h0D;
      4'hD: decode = 7'h3D;
      4'hE: decode = 7'h4F;
      default: decode = 7'h47;
    endcase
  endfunction
  assign dead = pre == PW'(SCAN_DIV - 1);
  // split shadow into nibbles and flag digits above the most significant non-zero nibble
  always_comb begin
    nz = 1'b0;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib[i] = shadow[4*i +: 4];
      nz = nz | (nib[i] != 4'h0);
      blank[i] = lz_en && (i != 0) && !nz;
    end
  end
  // shadow latch, prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      pre    <= '0;
      idx    <= '0;
    end else begin
      if (load) shadow <= value;
      pre <= dead ? '0 : pre + 1'b1;
      if (dead) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end
  // registered outputs: dark on the dead cycle or a blanked digit, else the decoded nibble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= '0;
      dig_en  <= '0;
    end else begin
      seg_out <= (dead || blank[idx]) ? 7'h00 : decode(nib[idx]);
      dig_en  <= (dead || blank[idx]) ? '0 : NUM_DIGITS'(1) << idx;
    end
  end
endmodule

// File: tb/tb_disp_freq_scan.sv
// tb_disp_freq_scan: directed self-checking bench for disp_freq_scan (4 digits, 4-cycle slots)
module tb_disp_freq_scan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg_out;
  logic [3:0]  dig_en;
  int          n_tests = 0;
  int          n_fail = 0;
  disp_freq_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .lz_en(lz_en), .seg_out(seg_out), .dig_en(dig_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic frame(input string name, input logic [6:0] e3, e2, e1, e0,
                       input logic ld, input logic [15:0] v, input logic lz);
    logic [6:0] e [4];
    int s;
    e = '{e0, e1, e2, e3};
    for (int c = 0; c < 16; c++) begin
      if (c == 15) begin
        load = ld;
        value = v;
        lz_en = lz;
      end
      step();
      s = c / 4;
      if (c % 4 == 3) begin
        chk($sformatf("%s c%0d seg", name, c), 32'(seg_out), 32'h0);
        chk($sformatf("%s c%0d en", name, c), 32'(dig_en), 32'h0);
      end else begin
        chk($sformatf("%s c%0d seg", name, c), 32'(seg_out), 32'(e[s]));
        chk($sformatf("%s c%0d en", name, c), 32'(dig_en), (e[s] == 7'h00) ? 32'h0 : (32'h1 << s));
      end
    end
    load = 1'b0;
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset seg", 32'(seg_out), 32'h0);
    chk("reset en", 32'(dig_en), 32'h0);
    step();
    chk("reset hold seg", 32'(seg_out), 32'h0);
    chk("reset hold en", 32'(dig_en), 32'h0);
    rst_n = 1'b1;
    frame("scan0", 7'h7E, 7'h7E, 7'h7E, 7'h7E, 1'b0, 16'h0000, 1'b0);
    frame("scan1", 7'h7E, 7'h7E, 7'h7E, 7'h7E, 1'b1, 16'h0042, 1'b1);
    frame("lz42", 7'h00, 7'h00, 7'h33, 7'h6D, 1'b0, 16'h0000, 1'b0);
    frame("nolz42", 7'h7E, 7'h7E, 7'h33, 7'h6D, 1'b1, 16'h0000, 1'b1);
    frame("zero", 7'h00, 7'h00, 7'h00, 7'h7E, 1'b1, 16'h1000, 1'b1);
    frame("1000", 7'h30, 7'h7E, 7'h7E, 7'h7E, 1'b1, 16'h0123, 1'b1);
    frame("0123", 7'h00, 7'h30, 7'h6D, 7'h79, 1'b1, 16'h4567, 1'b1);
    frame("4567", 7'h33, 7'h5B, 7'h5F, 7'h70, 1'b1, 16'h89AB, 1'b1);
    frame("89ab", 7'h7F, 7'h73, 7'h77, 7'h1F, 1'b1, 16'hCDEF, 1'b1);
    frame("cdef", 7'h0D, 7'h3D, 7'h4F, 7'h47, 1'b0, 16'h0000, 1'b1);
    step();
    chk("mid c0 seg", 32'(seg_out), 32'h47);
    load = 1'b1;
    value = 16'h0009;
    step();
    chk("mid L seg", 32'(seg_out), 32'h47);
    chk("mid L en", 32'(dig_en), 32'h1);
    load = 1'b0;
    step();
    chk("mid L+1 seg", 32'(seg_out), 32'h73);
    chk("mid L+1 en", 32'(dig_en), 32'h1);
    lz_en = 1'b0;
    step();
    chk("mid dead en", 32'(dig_en), 32'h0);
    step();
    chk("mid d1 seg", 32'(seg_out), 32'h7E);
    chk("mid d1 en", 32'(dig_en), 32'h2);
    step();
    step();
    step();
    step();
    chk("pre-rst d2 seg", 32'(seg_out), 32'h7E);
    chk("pre-rst d2 en", 32'(dig_en), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst seg", 32'(seg_out), 32'h0);
    chk("async rst en", 32'(dig_en), 32'h0);
    lz_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    frame("post-rst", 7'h00, 7'h00, 7'h00, 7'h7E, 1'b0, 16'h0000, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
